alu_seq_ctrl: RTL

Multi-byte arithmetic sequencer for the 8-bit ALU. It accepts one NBYTES-wide operation through a valid/ready request port, then drives the ALU one byte per cycle, least significant byte first, carrying the ALU carry-out into the next byte. It assembles the result with C/Z/N flags and holds it on a valid/ready response port. It sits between instruction decode and the ALU and owns the ALU's carry chain.

---
 rtl/alu_seq_ctrl_pkg.sv | 25 ++
 rtl/alu_seq_ctrl_if.sv | 28 ++
 rtl/alu_seq_flags.sv | 20 ++
 rtl/alu_seq_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: op codes, the
// arithmetic/logic classification and the controller state encoding.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] OP_OR  = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_EOR = 3'b010;
    localparam logic [2:0] OP_ADC = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_SBC = 3'b110;
    localparam logic [2:0] OP_TRB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Arithmetic ops chain the ALU carry between bytes; logic ops never do.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADC) || (op == OP_INC) || (op == OP_DEC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between instruction decode and the
// multi-byte ALU sequencer.
interface alu_seq_ctrl_if #(
    parameter int NBYTES = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [8*NBYTES-1:0]   req_a;
    logic [8*NBYTES-1:0]   req_b;
    logic                  req_ci;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_data;
    logic                  rsp_c;
    logic                  rsp_z;
    logic                  rsp_n;

    modport master (
        output req_valid, req_op, req_a, req_b, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_ci, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n
    );
endinterface

// File: rtl/alu_seq_flags.sv
// Result flags for a fully assembled multi-byte result: carry is kept only
// for arithmetic ops, zero and negative look at the whole word.
module alu_seq_flags
    import alu_seq_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] result,
    input  logic         carry,
    input  logic [2:0]   op,
    output logic         c,
    output logic         z,
    output logic         n
);

    assign c = is_arith(op) & carry;
    assign z = (result == '0);
    assign n = result[W-1];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-byte arithmetic sequencer: accepts one NBYTES-wide op, feeds the
// external 8-bit ALU LSB first while owning its carry chain, then holds the result.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 2,
    parameter int CNT_W  = $clog2(NBYTES) + 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_ctrl_if.slave bus,
    output logic [7:0]   alu_r,
    output logic [7:0]   alu_m,
    output logic [4:0]   alu_op,
    output logic         alu_ci,
    input  logic [7:0]   alu_out,
    input  logic         alu_co
);

    localparam int               W      = 8 * NBYTES;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NBYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] k;
    logic             carry_q;
    logic             ci_q;
    logic [2:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     res_q;
    logic [W-1:0]     res_nxt;
    logic             arith_q;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;

    assign arith_q = is_arith(op_q);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        alu_r  = '0;
        alu_m  = '0;
        alu_op = '0;
        alu_ci = 1'b0;
        if (state == RUN) begin
            alu_r  = a_q[8*k +: 8];
            alu_m  = b_q[8*k +: 8];
            alu_op = {2'b00, op_q};
            alu_ci = arith_q & ((k == '0) ? ci_q : carry_q);
        end
    end

    // Result with the byte the ALU is producing this cycle merged in, so the
    // flags on the final edge see the complete word.
    always_comb begin
        res_nxt = res_q;
        res_nxt[8*k +: 8] = alu_out;
    end

    alu_seq_flags #(
        .W (W)
    ) u_flags (
        .result (res_nxt),
        .carry  (alu_co),
        .op     (op_q),
        .c      (flag_c),
        .z      (flag_z),
        .n      (flag_n)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            carry_q       <= 1'b0;
            ci_q          <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_c     <= 1'b0;
            bus.rsp_z     <= 1'b0;
            bus.rsp_n     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        a_q           <= bus.req_a;
                        b_q           <= bus.req_b;
                        ci_q          <= bus.req_ci;
                        k             <= '0;
                        res_q         <= '0;
                        bus.req_ready <= 1'b0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_nxt;
                    carry_q <= alu_co;
                    if (k == K_LAST) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= res_nxt;
                        bus.rsp_c     <= flag_c;
                        bus.rsp_z     <= flag_z;
                        bus.rsp_n     <= flag_n;
                        state         <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    // Ready rises only after the handshake edge: no same-cycle turnaround.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
